// File: rtl/cmd_scheduler.sv
// Command scheduler: pops timestamped commands from the command FIFO, holds each
// until global_clock reaches its start time, then dispatches it over valid/ready.
module cmd_scheduler #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       global_clock,
    input  logic              run,
    input  logic              flush,
    input  logic              clear_counters,
    input  logic [79:0]       cmd_fifo_data_out,
    input  logic              cmd_fifo_empty,
    output logic              cmd_fifo_rd_en,
    output logic [ADDR_W-1:0] dispatch_addr,
    output logic [31:0]       dispatch_data,
    output logic              dispatch_valid,
    input  logic              dispatch_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  dispatch_count,
    output logic [CNT_W-1:0]  late_count,
    output logic [CNT_W-1:0]  timeout_count
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, POP, LOAD, WAIT, DISPATCH} state_t;

    state_t        state;
    logic [31:0]   t_reg;
    logic          imm_reg;
    logic [TW-1:0] tmo_cnt;

    logic [31:0] diff;
    logic        due;
    logic        late_evt;
    logic        accept;
    logic        expire;
    logic        unused_bits;

    // Signed modulo-2^32 distance keeps the due test correct across wrap.
    assign diff     = global_clock - t_reg;
    assign due      = imm_reg | ~diff[31];
    assign late_evt = (state == WAIT) & due & ~imm_reg & (diff != 32'd0) & ~flush;
    assign accept   = (state == DISPATCH) & dispatch_ready & ~flush;
    assign expire   = (state == DISPATCH) & ~dispatch_ready & (tmo_cnt == '0) & ~flush;

    // Pop strobe is masked combinationally so a flush or reset in POP never pops.
    assign cmd_fifo_rd_en = (state == POP) & ~flush & ~rst;
    assign busy           = (state != IDLE);
    assign unused_bits    = ^cmd_fifo_data_out[79:65];

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            dispatch_valid <= 1'b0;
            dispatch_addr  <= '0;
            dispatch_data  <= '0;
            t_reg          <= '0;
            imm_reg        <= 1'b0;
            tmo_cnt        <= '0;
        end else if (flush) begin
            state          <= IDLE;
            dispatch_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (run && !cmd_fifo_empty) state <= POP;
                POP:  state <= LOAD;
                LOAD: begin
                    dispatch_addr <= cmd_fifo_data_out[72 +: ADDR_W];
                    dispatch_data <= cmd_fifo_data_out[31:0];
                    t_reg         <= cmd_fifo_data_out[63:32];
                    imm_reg       <= cmd_fifo_data_out[64];
                    state         <= WAIT;
                end
                WAIT: if (due) begin
                    state          <= DISPATCH;
                    dispatch_valid <= 1'b1;
                    tmo_cnt        <= TW'(TIMEOUT - 1);
                end
                DISPATCH: begin
                    // Ready on the final timeout cycle still counts as accepted.
                    if (dispatch_ready || tmo_cnt == '0) begin
                        state          <= IDLE;
                        dispatch_valid <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_counters) begin
            dispatch_count <= '0;
            late_count     <= '0;
            timeout_count  <= '0;
        end else begin
            if (accept) dispatch_count <= dispatch_count + 1'b1;
            if (late_evt && late_count != '1) late_count <= late_count + 1'b1;
            if (expire && timeout_count != '1) timeout_count <= timeout_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cmd_scheduler.sv
// Bench for cmd_scheduler: FIFO model, timed-dispatch vector table, scoreboard
// of accepted commands, and hand sequences for timeout, flush, run and reset.
module tb_cmd_scheduler;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       global_clock;
    logic              run = 1'b0;
    logic              flush = 1'b0;
    logic              clear_counters = 1'b0;
    logic [79:0]       cmd_fifo_data_out = '0;
    logic              cmd_fifo_empty = 1'b1;
    logic              cmd_fifo_rd_en;
    logic [ADDR_W-1:0] dispatch_addr;
    logic [31:0]       dispatch_data;
    logic              dispatch_valid;
    logic              dispatch_ready = 1'b0;
    logic              busy;
    logic [CNT_W-1:0]  dispatch_count;
    logic [CNT_W-1:0]  late_count;
    logic [CNT_W-1:0]  timeout_count;

    cmd_scheduler #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .global_clock(global_clock), .run(run), .flush(flush),
        .clear_counters(clear_counters), .cmd_fifo_data_out(cmd_fifo_data_out),
        .cmd_fifo_empty(cmd_fifo_empty), .cmd_fifo_rd_en(cmd_fifo_rd_en),
        .dispatch_addr(dispatch_addr), .dispatch_data(dispatch_data),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready), .busy(busy),
        .dispatch_count(dispatch_count), .late_count(late_count), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    // Time base: global_clock = gc_base + cycle count, retargeted by set_gc.
    logic [31:0] cyc = '0;
    logic [31:0] gc_base = '0;
    always @(posedge clk) cyc <= cyc + 32'd1;
    assign global_clock = gc_base + cyc;

    // FIFO model: data valid the cycle after rd_en, registered empty flag.
    logic [79:0] fifo_q[$];
    always @(posedge clk) begin
        if (cmd_fifo_rd_en && fifo_q.size() != 0) cmd_fifo_data_out <= fifo_q.pop_front();
        cmd_fifo_empty <= (fifo_q.size() == 0);
    end

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Every accepted dispatch must match the oldest expected command.
    always @(negedge clk) begin
        #1;
        if (!rst && !flush && dispatch_valid && dispatch_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_accept", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_addr", 32'(dispatch_addr), 32'(mon_e.addr));
                chk("sb_data", dispatch_data, mon_e.data);
            end
        end
    end

    task automatic set_gc(input logic [31:0] v);
        gc_base = v - cyc;
    endtask

    task automatic push_cmd(input logic [7:0] a, input logic imm, input logic [31:0] t,
                            input logic [31:0] d, input bit score);
        fifo_q.push_back({a, 7'($urandom), imm, t, d});
        if (score) sb.push_back('{a, d});
    endtask

    task automatic wait_valid(input string nm, output int n);
        n = 0;
        while (!dispatch_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!dispatch_valid) chk(nm, 32'(dispatch_valid), 32'd1);
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic        imm;
        logic [31:0] t;
        logic [31:0] data;
        logic [31:0] gc0;
        bit          chk_gc;
        logic [31:0] exp_gc;
        bit          chk_lat;
        int          late_inc;
    } vec_t;

    vec_t vt[6];
    int   exp_disp = 0;
    int   exp_late = 0;
    int   exp_tmo  = 0;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1);
    end

    initial begin : main
        int n;
        int rd_seen;
        bit v_seen;

        vt[0] = '{8'h05, 1'b0, 32'd100,        32'hCAFEBABE, 32'd90,         1'b1, 32'd101,  1'b0, 0};
        vt[1] = '{8'h12, 1'b0, 32'd10,         32'h11112222, 32'd500,        1'b0, 32'd0,    1'b1, 1};
        vt[2] = '{8'h7F, 1'b1, 32'hFFFFFFFF,   32'h33334444, 32'd600,        1'b0, 32'd0,    1'b1, 0};
        vt[3] = '{8'hA0, 1'b0, 32'h00000004,   32'h55556666, 32'hFFFFFFF0,   1'b1, 32'd5,    1'b0, 0};
        vt[4] = '{8'hFF, 1'b0, 32'd1004,       32'h77778888, 32'd1000,       1'b1, 32'd1005, 1'b1, 0};
        vt[5] = '{8'h44, 1'b0, 32'd2003,       32'h9999AAAA, 32'd2000,       1'b1, 32'd2005, 1'b1, 1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(dispatch_valid), 32'd0);
        chk("rst_rd_en", 32'(cmd_fifo_rd_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(dispatch_addr), 32'd0);
        chk("rst_data", dispatch_data, 32'd0);
        chk("rst_disp_cnt", 32'(dispatch_count), 32'd0);
        chk("rst_late_cnt", 32'(late_count), 32'd0);
        chk("rst_tmo_cnt", 32'(timeout_count), 32'd0);
        rst = 1'b0;
        run = 1'b1;
        dispatch_ready = 1'b1;
        @(negedge clk);

        // Timed, late, immediate and wrap-around dispatches
        for (int i = 0; i < 6; i++) begin
            set_gc(vt[i].gc0);
            push_cmd(vt[i].addr, vt[i].imm, vt[i].t, vt[i].data, 1'b1);
            @(negedge clk);
            chk("vec_empty_fell", 32'(cmd_fifo_empty), 32'd0);
            wait_valid("vec_valid_seen", n);
            if (vt[i].chk_lat) chk("vec_latency", 32'(n), 32'd4);
            if (vt[i].chk_gc) chk("vec_gc_at_valid", global_clock, vt[i].exp_gc);
            @(negedge clk);
            exp_disp++;
            exp_late += vt[i].late_inc;
            chk("vec_disp_cnt", 32'(dispatch_count), 32'(exp_disp));
            chk("vec_late_cnt", 32'(late_count), 32'(exp_late));
            chk("vec_idle", 32'(busy), 32'd0);
        end

        // Timeout: first command dropped after TIMEOUT cycles, second accepted on the last one
        dispatch_ready = 1'b0;
        push_cmd(8'h21, 1'b1, 32'd0, 32'hDEAD0001, 1'b0);
        push_cmd(8'h22, 1'b1, 32'd0, 32'hDEAD0002, 1'b1);
        @(negedge clk);
        wait_valid("tmo_valid_seen", n);
        n = 0;
        while (dispatch_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        exp_tmo++;
        chk("tmo_valid_cycles", 32'(n), 32'(TIMEOUT));
        chk("tmo_tmo_cnt", 32'(timeout_count), 32'(exp_tmo));
        chk("tmo_disp_cnt", 32'(dispatch_count), 32'(exp_disp));
        wait_valid("tmo2_valid_seen", n);
        for (int k = 1; k < TIMEOUT; k++) @(negedge clk);
        chk("tmo2_valid_last", 32'(dispatch_valid), 32'd1);
        dispatch_ready = 1'b1;
        @(negedge clk);
        exp_disp++;
        chk("tmo2_valid_low", 32'(dispatch_valid), 32'd0);
        chk("tmo2_disp_cnt", 32'(dispatch_count), 32'(exp_disp));
        chk("tmo2_tmo_cnt", 32'(timeout_count), 32'(exp_tmo));

        // Flush while waiting for a far-future timestamp
        set_gc(32'd0);
        push_cmd(8'h01, 1'b0, 32'd5000, 32'h0F0F0F0F, 1'b0);
        repeat (8) @(negedge clk);
        chk("flw_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flw_busy_low", 32'(busy), 32'd0);
        v_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dispatch_valid) v_seen = 1'b1;
        end
        chk("flw_no_valid", 32'(v_seen), 32'd0);
        chk("flw_disp_cnt", 32'(dispatch_count), 32'(exp_disp));

        // Flush in the POP cycle: no pop, command is taken later
        push_cmd(8'h02, 1'b1, 32'd0, 32'hF00DF00D, 1'b1);
        @(negedge clk);
        chk("flp_empty_fell", 32'(cmd_fifo_empty), 32'd0);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flp_rd_en_masked", 32'(cmd_fifo_rd_en), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("flp_fifo_count", 32'(fifo_q.size()), 32'd1);
        wait_valid("flp_valid_seen", n);
        @(negedge clk);
        exp_disp++;
        chk("flp_disp_cnt", 32'(dispatch_count), 32'(exp_disp));

        // run low holds off popping
        run = 1'b0;
        push_cmd(8'h03, 1'b1, 32'd0, 32'hBEEF0003, 1'b1);
        rd_seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_fifo_rd_en) rd_seen++;
        end
        chk("run_no_rd_en", 32'(rd_seen), 32'd0);
        run = 1'b1;
        wait_valid("run_valid_seen", n);
        @(negedge clk);
        exp_disp++;
        chk("run_disp_cnt", 32'(dispatch_count), 32'(exp_disp));
        chk("run_late_cnt", 32'(late_count), 32'(exp_late));

        // Reset during DISPATCH
        dispatch_ready = 1'b0;
        push_cmd(8'h04, 1'b1, 32'd0, 32'h44440004, 1'b0);
        wait_valid("rstd_valid_seen", n);
        rst = 1'b1;
        @(negedge clk);
        chk("rstd_valid", 32'(dispatch_valid), 32'd0);
        chk("rstd_busy", 32'(busy), 32'd0);
        chk("rstd_addr", 32'(dispatch_addr), 32'd0);
        chk("rstd_data", dispatch_data, 32'd0);
        chk("rstd_disp_cnt", 32'(dispatch_count), 32'd0);
        chk("rstd_late_cnt", 32'(late_count), 32'd0);
        chk("rstd_tmo_cnt", 32'(timeout_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // clear_counters in the same cycle as an accept: clear wins
        push_cmd(8'h05, 1'b1, 32'd0, 32'h55550005, 1'b1);
        wait_valid("clr_valid_seen", n);
        dispatch_ready = 1'b1;
        clear_counters = 1'b1;
        @(negedge clk);
        dispatch_ready = 1'b0;
        clear_counters = 1'b0;
        chk("clr_disp_cnt", 32'(dispatch_count), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_scheduler.md
Name: cmd_scheduler

Overview:
- Pops 80-bit commands from the command FIFO (filled by the EBI bridge).
- Holds each command until its timestamp matches global_clock, then dispatches it to the addressed pin controller over a valid/ready bus.
- Sits between the cmd FIFO read side and the pin-controller array.
- Keeps dispatch, late and timeout statistics for the host.

Parameters:
- ADDR_W, 8, width of the target address field taken from cmd[79:72]; must be <= 8.
- TIMEOUT, 1024, cycles dispatch_valid may stay high without dispatch_ready before the command is dropped; must be >= 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- global_clock  in  32  free-running time base from the EBI time register
- run  in  1  permits popping new commands
- flush  in  1  discards the held command, returns to IDLE
- clear_counters  in  1  zeroes all statistics counters
- cmd_fifo_data_out  in  80  FIFO read data, valid the cycle after rd_en
- cmd_fifo_empty  in  1  FIFO empty flag
- cmd_fifo_rd_en  out  1  FIFO pop strobe
- dispatch_addr  out  ADDR_W  target pin-controller address
- dispatch_data  out  32  command payload
- dispatch_valid  out  1  dispatch request
- dispatch_ready  in  1  target accepts
- busy  out  1  state != IDLE
- dispatch_count  out  CNT_W  commands accepted by targets; wraps
- late_count  out  CNT_W  commands dispatched after their timestamp; saturates
- timeout_count  out  CNT_W  commands dropped on timeout; saturates

Behaviour:
- Command format:
  - [79:72] target address; low ADDR_W bits are used.
  - [64] immediate flag.
  - [71:65] reserved, ignored.
  - [63:32] start time T.
  - [31:0] payload.
- Reset: state=IDLE. cmd_fifo_rd_en, dispatch_valid and busy are 0. dispatch_addr, dispatch_data and all counters are 0.
- States:
  - IDLE: if run & ~cmd_fifo_empty, go to POP.
  - POP: cmd_fifo_rd_en=1 for exactly this cycle; go to LOAD.
  - LOAD: register addr, payload, T and the immediate flag from cmd_fifo_data_out; go to WAIT.
  - WAIT: diff = global_clock - T, taken as modulo-2^32 signed. due = immediate | ~diff[31]. If due, go to DISPATCH.
  - DISPATCH: dispatch_valid=1 (registered); addr and data are stable. When valid & ready is sampled, dispatch_count+1 and go to IDLE. If TIMEOUT cycles pass without ready, drop the command, timeout_count+1, go to IDLE.
- Timing and latency:
  - If global_clock==T in a WAIT cycle n, dispatch_valid is high in cycle n+1.
  - From empty FIFO going low to dispatch_valid is 4 cycles minimum, for an immediate or past-due command.
  - Back-to-back: IDLE is visited for one cycle between commands.
- Late: a non-immediate command leaving WAIT with diff != 0, and diff[31]=0, increments late_count. It is still dispatched. Immediate commands are never late.
- Wrap-around: the comparison is wrap-safe. T=0x00000002 is due once global_clock has wrapped from 0xFFFFFFFF. A target more than 2^31 behind is treated as future.
- run is sampled only in IDLE. Deasserting run lets the in-flight command complete.
- flush has priority over everything except rst:
  - Next state is IDLE, and dispatch_valid goes low the next cycle.
  - cmd_fifo_rd_en is forced to 0 in a POP cycle that has flush high, so no pop occurs.
  - A command already loaded is discarded uncounted.
  - Counters are unaffected.
- Simultaneous events:
  - If ready arrives in the same cycle the timeout expires, the command counts as accepted, not as a timeout.
  - clear_counters together with an increment: clear wins.
  - Counters saturate at all-ones, except dispatch_count, which wraps.
- The timeout counter reloads on entry to DISPATCH.
- Reset mid-operation returns everything to the reset values on the next edge. No pop is issued in that cycle.

Test Plan:
- Timed dispatch: FIFO holds {addr=0x05, T=100, payload=0xCAFEBABE}, global_clock starts at 90, run=1. Required: dispatch_valid rises exactly one cycle after global_clock==100, addr=5, data=0xCAFEBABE; ready=1 gives dispatch_count=1 and late_count=0.
- Late and immediate: T=10 while global_clock=500 -> dispatched at once, late_count=1. Next command immediate=1 with T=0xFFFFFFFF -> dispatched within 4 cycles, late_count stays 1.
- Wrap: global_clock starts at 0xFFFFFFF0 with T=0x00000004 -> no dispatch before the wrap; dispatch_valid rises one cycle after global_clock==4.
- Timeout: TIMEOUT=16, dispatch_ready held 0 -> valid drops after 16 cycles, timeout_count=1, dispatch_count=0, next command popped. A second run with ready asserted on the 16th cycle counts as accepted.
- Flush: flush during WAIT -> busy=0 next cycle, no dispatch. Flush during POP -> cmd_fifo_rd_en stays 0 and the FIFO count is unchanged.
- Run/reset: run=0 with a non-empty FIFO -> no rd_en for 50 cycles. rst during DISPATCH -> dispatch_valid=0, all counters 0 next cycle.
